fetch_stage: RTL and testbench

Instruction-fetch stage of the five-stage pipelined CPU. It owns the PC, drives a request/acknowledge instruction-memory port that may take any number of cycles, and writes the IF/ID pipeline register. It takes the PC-write and IF/ID-stall controls from the load-use hazard logic and branch redirects from ID. A skid buffer keeps an instruction that returns while the pipeline is stalled.

---
 rtl/fetch_stage.sv | 189 ++++++++++++++++++
 tb/tb_fetch_stage.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, runs a req/ack instruction-memory port of arbitrary
// latency, and writes the IF/ID pipeline register. A one-entry skid buffer holds an instruction
// that returns while the pipeline is stalled. A branch redirect that arrives while a request is
// still outstanding is parked until that request completes, and its data is then thrown away.
module fetch_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        pc_write_i,
  input  logic        stall_i,
  input  logic        flush_i,
  input  logic [31:0] branch_target_i,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  input  logic        imem_ack_i,
  input  logic [31:0] imem_data_i,
  output logic [31:0] ifid_pc_o,
  output logic [31:0] ifid_instr_o,
  output logic        ifid_valid_o,
  output logic [31:0] fetch_count_o
);

  // Fetch FSM encoding
  localparam logic [1:0] StFetch = 2'd0;  // request outstanding at pc
  localparam logic [1:0] StHold  = 2'd1;  // skid buffer full, no request
  localparam logic [1:0] StDrop  = 2'd2;  // stale request pending, result discarded

  logic [1:0]  state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] skid_pc_q, skid_pc_d;
  logic [31:0] skid_instr_q, skid_instr_d;
  logic [31:0] redirect_q, redirect_d;
  logic [31:0] ifid_pc_q, ifid_pc_d;
  logic [31:0] ifid_instr_q, ifid_instr_d;
  logic        ifid_valid_q, ifid_valid_d;
  logic [31:0] fetch_count_q, fetch_count_d;

  logic        hold;
  logic        advance;
  logic        ack;
  logic        load_valid;
  logic [31:0] pc_plus4;
  logic [31:0] target_aligned;

  assign hold           = stall_i | ~pc_write_i;
  assign advance        = ~hold & ~flush_i;
  assign pc_plus4       = pc_q + 32'd4;
  assign target_aligned = {branch_target_i[31:2], 2'b00};

  // Request is decoded from state only; reset forces it low so a pending access is abandoned
  always_comb begin
    imem_req_o  = rst_i & ((state_q == StFetch) | (state_q == StDrop));
    imem_addr_o = pc_q;
  end

  // An ack only counts while a request is actually being presented
  assign ack = imem_req_o & imem_ack_i;

  // Next-state logic for the FSM, PC, skid buffer, redirect and IF/ID register
  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    skid_pc_d    = skid_pc_q;
    skid_instr_d = skid_instr_q;
    redirect_d   = redirect_q;
    ifid_pc_d    = ifid_pc_q;
    ifid_instr_d = ifid_instr_q;
    ifid_valid_d = ifid_valid_q;
    load_valid   = 1'b0;

    case (state_q)
      StFetch: begin
        if (flush_i) begin
          ifid_pc_d    = pc_q;
          ifid_instr_d = NOP_INSTR;
          ifid_valid_d = 1'b0;
          if (ack) begin
            // Returned word belongs to the wrong path; redirect right away
            pc_d = target_aligned;
          end else begin
            // Request still in flight; address must stay put until it completes
            redirect_d = target_aligned;
            state_d    = StDrop;
          end
        end else if (ack) begin
          if (advance) begin
            ifid_pc_d    = pc_q;
            ifid_instr_d = imem_data_i;
            ifid_valid_d = 1'b1;
            load_valid   = 1'b1;
            pc_d         = pc_plus4;
          end else begin
            skid_pc_d    = pc_q;
            skid_instr_d = imem_data_i;
            state_d      = StHold;
          end
        end else if (advance) begin
          ifid_pc_d    = pc_q;
          ifid_instr_d = NOP_INSTR;
          ifid_valid_d = 1'b0;
        end
      end

      StHold: begin
        if (flush_i) begin
          ifid_pc_d    = pc_q;
          ifid_instr_d = NOP_INSTR;
          ifid_valid_d = 1'b0;
          pc_d         = target_aligned;
          state_d      = StFetch;
        end else if (advance) begin
          ifid_pc_d    = skid_pc_q;
          ifid_instr_d = skid_instr_q;
          ifid_valid_d = 1'b1;
          load_valid   = 1'b1;
          pc_d         = pc_plus4;
          state_d      = StFetch;
        end
      end

      StDrop: begin
        if (flush_i) begin
          ifid_pc_d    = pc_q;
          ifid_instr_d = NOP_INSTR;
          ifid_valid_d = 1'b0;
          // Newest target wins, even if the stale request completes this cycle
          if (ack) begin
            pc_d    = target_aligned;
            state_d = StFetch;
          end else begin
            redirect_d = target_aligned;
          end
        end else begin
          if (advance) begin
            ifid_pc_d    = pc_q;
            ifid_instr_d = NOP_INSTR;
            ifid_valid_d = 1'b0;
          end
          if (ack) begin
            pc_d    = redirect_q;
            state_d = StFetch;
          end
        end
      end

      default: begin
        state_d = StFetch;
      end
    endcase

    fetch_count_d = fetch_count_q;
    if (load_valid) begin
      fetch_count_d = fetch_count_q + 32'd1;
    end
  end

  // State registers with synchronous active-low reset
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state_q       <= StFetch;
      pc_q          <= RESET_PC;
      skid_pc_q     <= 32'd0;
      skid_instr_q  <= 32'd0;
      redirect_q    <= 32'd0;
      ifid_pc_q     <= 32'd0;
      ifid_instr_q  <= NOP_INSTR;
      ifid_valid_q  <= 1'b0;
      fetch_count_q <= 32'd0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      skid_pc_q     <= skid_pc_d;
      skid_instr_q  <= skid_instr_d;
      redirect_q    <= redirect_d;
      ifid_pc_q     <= ifid_pc_d;
      ifid_instr_q  <= ifid_instr_d;
      ifid_valid_q  <= ifid_valid_d;
      fetch_count_q <= fetch_count_d;
    end
  end

  assign ifid_pc_o     = ifid_pc_q;
  assign ifid_instr_o  = ifid_instr_q;
  assign ifid_valid_o  = ifid_valid_q;
  assign fetch_count_o = fetch_count_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: a variable-latency memory model answering addr ^ 32'hA5A5_0000,
// a table of per-cycle vectors for streaming/stall behaviour, hand sequences for flush,
// drop and reset corners, and a scoreboard of expected IF/ID loads.
module tb_fetch_stage;

  logic        clk = 1'b0;
  logic        rst_i;
  logic        pc_write;
  logic        stall;
  logic        flush;
  logic [31:0] target;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_data;
  logic [31:0] ifid_pc;
  logic [31:0] ifid_instr;
  logic        ifid_valid;
  logic [31:0] fetch_count;

  always #5 clk = ~clk;

  fetch_stage #(
    .RESET_PC (32'h0000_0000),
    .NOP_INSTR(32'h0000_0013)
  ) dut (
    .clk_i          (clk),
    .rst_i          (rst_i),
    .pc_write_i     (pc_write),
    .stall_i        (stall),
    .flush_i        (flush),
    .branch_target_i(target),
    .imem_req_o     (imem_req),
    .imem_addr_o    (imem_addr),
    .imem_ack_i     (imem_ack),
    .imem_data_i    (imem_data),
    .ifid_pc_o      (ifid_pc),
    .ifid_instr_o   (ifid_instr),
    .ifid_valid_o   (ifid_valid),
    .fetch_count_o  (fetch_count)
  );

  // Memory model: ack after 'waits' full cycles of an asserted request
  int unsigned waits = 0;
  int unsigned wcnt  = 0;
  assign imem_ack  = imem_req && (wcnt >= waits);
  assign imem_data = imem_addr ^ 32'hA5A5_0000;
  always @(posedge clk) begin
    if (!imem_req || imem_ack) wcnt <= 0;
    else wcnt <= wcnt + 1;
  end

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
  } load_t;
  load_t       sb_q[$];
  logic [31:0] last_count = 32'd0;

  typedef struct {
    int unsigned waits;
    logic        stall;
    logic        pcw;
    logic        push;
    logic [31:0] push_pc;
    logic        req;
    logic [31:0] addr;
    logic        valid;
    logic [31:0] pc;
    logic [31:0] count;
  } vec_t;
  vec_t vecs[17];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic push_load(input logic [31:0] pc);
    load_t e;
    e.pc    = pc;
    e.instr = pc ^ 32'hA5A5_0000;
    sb_q.push_back(e);
  endtask

  // Advance one edge, sample at the falling edge, retire any IF/ID load against the scoreboard
  task automatic tick();
    load_t e;
    @(posedge clk);
    @(negedge clk);
    if (rst_i && fetch_count !== last_count) begin
      if (sb_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_load: got pc %h, none expected", ifid_pc);
      end else begin
        e = sb_q.pop_front();
        check("load_pc", ifid_pc, e.pc);
        check("load_instr", ifid_instr, e.instr);
      end
    end
    last_count = fetch_count;
  endtask

  task automatic cycle(input logic st, input logic pw, input logic fl, input logic [31:0] tgt);
    stall    = st;
    pc_write = pw;
    flush    = fl;
    target   = tgt;
    tick();
  endtask

  task automatic expect_out(input string tag, input logic req, input logic [31:0] addr,
                            input logic valid, input logic [31:0] count);
    check({tag, "_req"}, {31'd0, imem_req}, {31'd0, req});
    if (req) check({tag, "_addr"}, imem_addr, addr);
    check({tag, "_valid"}, {31'd0, ifid_valid}, {31'd0, valid});
    check({tag, "_count"}, fetch_count, count);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    //          waits st pw push pushpc  req addr     v pc       count
    vecs[0]  = '{0, 0, 1, 1, 32'h00, 1, 32'h04, 1, 32'h00, 32'd1};
    vecs[1]  = '{0, 0, 1, 1, 32'h04, 1, 32'h08, 1, 32'h04, 32'd2};
    vecs[2]  = '{0, 0, 1, 1, 32'h08, 1, 32'h0C, 1, 32'h08, 32'd3};
    vecs[3]  = '{2, 0, 1, 0, 32'h00, 1, 32'h0C, 0, 32'h00, 32'd3};
    vecs[4]  = '{2, 0, 1, 0, 32'h00, 1, 32'h0C, 0, 32'h00, 32'd3};
    vecs[5]  = '{2, 0, 1, 1, 32'h0C, 1, 32'h10, 1, 32'h0C, 32'd4};
    vecs[6]  = '{2, 0, 1, 0, 32'h00, 1, 32'h10, 0, 32'h00, 32'd4};
    vecs[7]  = '{2, 0, 1, 0, 32'h00, 1, 32'h10, 0, 32'h00, 32'd4};
    vecs[8]  = '{2, 0, 1, 1, 32'h10, 1, 32'h14, 1, 32'h10, 32'd5};
    vecs[9]  = '{0, 1, 1, 0, 32'h00, 0, 32'h00, 1, 32'h10, 32'd5};
    vecs[10] = '{0, 1, 1, 0, 32'h00, 0, 32'h00, 1, 32'h10, 32'd5};
    vecs[11] = '{0, 1, 1, 0, 32'h00, 0, 32'h00, 1, 32'h10, 32'd5};
    vecs[12] = '{0, 0, 1, 1, 32'h14, 1, 32'h18, 1, 32'h14, 32'd6};
    vecs[13] = '{0, 0, 0, 0, 32'h00, 0, 32'h00, 1, 32'h14, 32'd6};
    vecs[14] = '{0, 0, 1, 1, 32'h18, 1, 32'h1C, 1, 32'h18, 32'd7};
    vecs[15] = '{1, 1, 1, 0, 32'h00, 1, 32'h1C, 1, 32'h18, 32'd7};
    vecs[16] = '{1, 0, 1, 1, 32'h1C, 1, 32'h20, 1, 32'h1C, 32'd8};

    rst_i    = 1'b0;
    stall    = 1'b0;
    pc_write = 1'b1;
    flush    = 1'b0;
    target   = 32'd0;
    @(negedge clk);
    check("reset_req_low", {31'd0, imem_req}, 32'd0);
    tick();
    tick();
    check("reset_ifid_pc", ifid_pc, 32'd0);
    check("reset_ifid_instr", ifid_instr, 32'h0000_0013);
    check("reset_valid", {31'd0, ifid_valid}, 32'd0);
    check("reset_count", fetch_count, 32'd0);
    rst_i = 1'b1;
    #1;
    expect_out("first_req", 1'b1, 32'h0, 1'b0, 32'd0);

    // Streaming, wait states, stall/pc_write hold and skid replay
    for (int i = 0; i < 17; i++) begin
      waits = vecs[i].waits;
      if (vecs[i].push) push_load(vecs[i].push_pc);
      cycle(vecs[i].stall, vecs[i].pcw, 1'b0, 32'd0);
      expect_out($sformatf("vec%0d", i), vecs[i].req, vecs[i].addr, vecs[i].valid,
                 vecs[i].count);
      if (vecs[i].valid) check($sformatf("vec%0d_ifid_pc", i), ifid_pc, vecs[i].pc);
    end

    // Flush while a 3-wait request to 0x20 is pending
    waits = 3;
    cycle(1'b0, 1'b1, 1'b1, 32'h100);
    expect_out("d1_flush", 1'b1, 32'h20, 1'b0, 32'd8);
    cycle(1'b0, 1'b1, 1'b0, 32'h0);
    expect_out("d1_wait1", 1'b1, 32'h20, 1'b0, 32'd8);
    cycle(1'b0, 1'b1, 1'b0, 32'h0);
    expect_out("d1_wait2", 1'b1, 32'h20, 1'b0, 32'd8);
    cycle(1'b0, 1'b1, 1'b0, 32'h0);
    expect_out("d1_redirect", 1'b1, 32'h100, 1'b0, 32'd8);

    // Second flush during DROP: newest target wins
    cycle(1'b0, 1'b1, 1'b1, 32'h180);
    expect_out("d2_flush1", 1'b1, 32'h100, 1'b0, 32'd8);
    cycle(1'b0, 1'b1, 1'b1, 32'h200);
    expect_out("d2_flush2", 1'b1, 32'h100, 1'b0, 32'd8);
    cycle(1'b0, 1'b1, 1'b0, 32'h0);
    expect_out("d2_wait", 1'b1, 32'h100, 1'b0, 32'd8);
    cycle(1'b0, 1'b1, 1'b0, 32'h0);
    expect_out("d2_redirect", 1'b1, 32'h200, 1'b0, 32'd8);
    waits = 0;
    push_load(32'h200);
    cycle(1'b0, 1'b1, 1'b0, 32'h0);
    expect_out("d2_load", 1'b1, 32'h204, 1'b1, 32'd9);

    // Flush + stall + ack together, then flush out of HOLD with a misaligned target
    cycle(1'b0, 1'b1, 1'b1, 32'h40);
    expect_out("e_goto40", 1'b1, 32'h40, 1'b0, 32'd9);
    cycle(1'b1, 1'b1, 1'b1, 32'h80);
    expect_out("e_flush_stall_ack", 1'b1, 32'h80, 1'b0, 32'd9);
    cycle(1'b1, 1'b1, 1'b0, 32'h0);
    expect_out("e_hold", 1'b0, 32'h0, 1'b0, 32'd9);
    cycle(1'b1, 1'b1, 1'b1, 32'h93);
    expect_out("e_hold_flush", 1'b1, 32'h90, 1'b0, 32'd9);

    // Reset in the middle of a pending request to 0x30
    cycle(1'b0, 1'b1, 1'b1, 32'h30);
    expect_out("f_goto30", 1'b1, 32'h30, 1'b0, 32'd9);
    waits = 5;
    cycle(1'b0, 1'b1, 1'b0, 32'h0);
    expect_out("f_pending", 1'b1, 32'h30, 1'b0, 32'd9);
    rst_i = 1'b0;
    #1;
    check("f_req_drops", {31'd0, imem_req}, 32'd0);
    tick();
    check("f_rst_req", {31'd0, imem_req}, 32'd0);
    check("f_rst_valid", {31'd0, ifid_valid}, 32'd0);
    check("f_rst_count", fetch_count, 32'd0);
    check("f_rst_instr", ifid_instr, 32'h0000_0013);
    rst_i = 1'b1;
    #1;
    expect_out("f_after", 1'b1, 32'h0, 1'b0, 32'd0);
    waits = 0;
    push_load(32'h0);
    cycle(1'b0, 1'b1, 1'b0, 32'h0);
    expect_out("f_load0", 1'b1, 32'h4, 1'b1, 32'd1);

    check("sb_drained", sb_q.size(), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
